// File: rtl/cpu_serial_tx_pkg.sv
// Shared definitions for the serial result transmitter: FSM state encodings
// and frame-length constants for the default 8-bit result / 4-bit flag frame.
// Combinational only; no latency or backpressure of its own.
package cpu_serial_tx_pkg;

    // Transmitter FSM states (3-bit encoding).
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_FLAGS  = 3'd3,
        TX_PARITY = 3'd4,
        TX_DONE   = 3'd5
    } tx_state_t;

    // Frame composition for the default widths: start + result + flags + parity.
    localparam int TX_START_BITS  = 1;
    localparam int TX_DATA_BITS   = 8;
    localparam int TX_FLAG_BITS   = 4;
    localparam int TX_PARITY_BITS = 1;
    localparam int TX_FRAME_LEN   = TX_START_BITS + TX_DATA_BITS
                                  + TX_FLAG_BITS + TX_PARITY_BITS;

    // Width of a counter able to index max(a,b) positions (never below 1).
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/cpu_tx_shifter.sv
// Parallel-load, MSB-first shift register feeding the serial data line.
// Latency: load/shift take effect at the next clk edge; msb is the current top bit.
// Backpressure: none; load has priority over shift.
//   clk, rst  : clock, synchronous active-high reset (clears contents)
//   load, din : capture din into the register
//   shift     : shift left by one, zero-filling the LSB
//   msb       : current most significant bit
module cpu_tx_shifter #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/cpu_serial_tx.sv
// Serial result transmitter: start strobe, then result, flags and even parity MSB first.
// Latency: tx_start one cycle after an accepted load; done 15 cycles after it (8/4 widths).
// Backpressure: none; a load while busy is dropped and sets the sticky overrun flag.
//   clk, rst           : clock, synchronous active-high reset
//   load, result, flags: capture request and payload (accepted only when idle)
//   clr_ovr            : clears overrun (a coincident overrun event wins)
//   tx_start, tx_data  : frame strobe and serial data line
//   busy, done, overrun: frame in progress, end-of-frame pulse, sticky drop flag
module cpu_serial_tx
    import cpu_serial_tx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] result,
    input  logic [FLAG_W-1:0] flags,
    input  logic              clr_ovr,
    output logic              tx_start,
    output logic              tx_data,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int SR_W  = DATA_W + FLAG_W + 1;
    localparam int CNT_W = cnt_width(DATA_W, FLAG_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FLAG_LAST = CNT_W'(FLAG_W - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             sr_load;
    logic             sr_shift;
    logic             sr_msb;
    logic             parity;

    // Even parity: total ones over result, flags and this bit is even.
    assign parity = ^{result, flags};

    // Only a load seen in TX_IDLE captures; TX_DONE has busy low but still refuses.
    assign sr_load = (state == TX_IDLE) && load;

    // Each shift presents the next bit on the following edge, so shifting
    // starts in TX_START and stops after the last flag bit exposes parity.
    assign sr_shift = (state == TX_START) || (state == TX_DATA) || (state == TX_FLAGS);

    cpu_tx_shifter #(
        .WIDTH (SR_W)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .din   ({result, flags, parity}),
        .msb   (sr_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            cnt      <= '0;
            tx_start <= 1'b0;
            tx_data  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (load) begin
                        state    <= TX_START;
                        cnt      <= '0;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                TX_START: begin
                    state    <= TX_DATA;
                    cnt      <= '0;
                    tx_start <= 1'b0;
                    tx_data  <= sr_msb;
                end
                TX_DATA: begin
                    tx_data <= sr_msb;
                    if (cnt == DATA_LAST) begin
                        state <= TX_FLAGS;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_FLAGS: begin
                    tx_data <= sr_msb;
                    if (cnt == FLAG_LAST) begin
                        state <= TX_PARITY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_PARITY: begin
                    state   <= TX_DONE;
                    cnt     <= '0;
                    tx_data <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                TX_DONE: begin
                    state <= TX_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state    <= TX_IDLE;
                    cnt      <= '0;
                    tx_start <= 1'b0;
                    tx_data  <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun: a dropped load in the same cycle as clr_ovr still sets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (load && busy) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule
